// File: rtl/spine_uplink_scheduler.sv
// spine_uplink_scheduler: buffers egress flits in a small FIFO and dispatches
// them round-robin onto four credit-controlled spine uplinks.
module spine_uplink_scheduler #(
  parameter int unsigned DWIDTH        = 16,
  parameter int unsigned CREDITS       = 4,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned STALL_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DWIDTH-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    spine_enable,
  input  logic [3:0]                    credit_return,
  output logic [DWIDTH-1:0]             out_data,
  output logic [3:0]                    out_valid,
  output logic [1:0]                    last_grant,
  output logic                          stall,
  output logic                          stall_timeout,
  output logic                          credit_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned SCW = $clog2(STALL_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  logic [DWIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [2:0]        r_credit [4];
  logic [1:0]        r_rr_ptr;
  logic [SCW-1:0]    r_stall_cnt;
  state_t            r_state;
  state_t            w_state_next;

  logic              w_push;
  logic              w_pop;
  logic              w_any_elig;
  logic [3:0]        w_elig;
  logic [1:0]        w_grant;
  logic [3:0]        w_grant_oh;
  logic [2:0]        w_credit_next [4];
  logic [3:0]        w_credit_ovf;
  logic [CW-1:0]     w_count_next;

  assign in_ready     = (r_count != CW'(FIFO_DEPTH));
  assign fifo_count   = r_count;
  assign stall        = (r_state == STALL);
  assign w_push       = in_valid && in_ready;
  assign w_pop        = (r_count != '0) && w_any_elig;
  assign w_grant_oh   = w_pop ? (4'b0001 << w_grant) : '0;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  // Spine eligibility: enabled and holding at least one credit
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      w_elig[i] = spine_enable[i] && (r_credit[i] != '0);
    end
  end

  // Round-robin pick: first eligible spine scanning upward from r_rr_ptr
  always_comb begin
    w_grant    = '0;
    w_any_elig = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!w_any_elig && w_elig[r_rr_ptr + 2'(k)]) begin
        w_grant    = r_rr_ptr + 2'(k);
        w_any_elig = 1'b1;
      end
    end
  end

  // Per-spine credit update; a return at full credit without a dispatch is an error
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      w_credit_next[i] = r_credit[i];
      w_credit_ovf[i]  = 1'b0;
      case ({w_grant_oh[i], credit_return[i]})
        2'b10:   w_credit_next[i] = r_credit[i] - 3'd1;
        2'b01: begin
          if (r_credit[i] == 3'(CREDITS)) w_credit_ovf[i] = 1'b1;
          else                            w_credit_next[i] = r_credit[i] + 3'd1;
        end
        default: w_credit_next[i] = r_credit[i];
      endcase
    end
  end

  // Next state from post-edge occupancy and credits
  always_comb begin
    w_state_next = IDLE;
    if (w_count_next != '0) begin
      w_state_next = STALL;
      for (int unsigned i = 0; i < 4; i++) begin
        if (spine_enable[i] && (w_credit_next[i] != '0)) w_state_next = RUN;
      end
    end
  end

  // FIFO storage (contents are don't-care until written)
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
    end
  end

  // Dispatch register and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data   <= '0;
      out_valid  <= '0;
      last_grant <= '0;
      r_rr_ptr   <= '0;
    end else begin
      out_valid <= w_grant_oh;
      if (w_pop) begin
        out_data   <= r_mem[r_rd_ptr];
        last_grant <= w_grant;
        r_rr_ptr   <= w_grant + 2'd1;
      end
    end
  end

  // Credit counters and sticky protocol error
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) r_credit[i] <= 3'(CREDITS);
      credit_err <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) r_credit[i] <= w_credit_next[i];
      if (|w_credit_ovf) credit_err <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Saturating stall counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt   <= '0;
      stall_timeout <= 1'b0;
    end else if (r_state != STALL) begin
      r_stall_cnt <= '0;
    end else if (r_stall_cnt != SCW'(STALL_TIMEOUT)) begin
      r_stall_cnt <= r_stall_cnt + SCW'(1);
      if (r_stall_cnt + SCW'(1) == SCW'(STALL_TIMEOUT)) stall_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spine_uplink_scheduler.sv
// Directed testbench for spine_uplink_scheduler.
module tb_spine_uplink_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  spine_enable = 4'b1111;
  logic [3:0]  credit_return = '0;
  logic [15:0] out_data;
  logic [3:0]  out_valid;
  logic [1:0]  last_grant;
  logic        stall;
  logic        stall_timeout;
  logic        credit_err;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  spine_uplink_scheduler #(
    .DWIDTH(16), .CREDITS(4), .FIFO_DEPTH(4), .STALL_TIMEOUT(64)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .spine_enable(spine_enable), .credit_return(credit_return),
    .out_data(out_data), .out_valid(out_valid), .last_grant(last_grant),
    .stall(stall), .stall_timeout(stall_timeout), .credit_err(credit_err),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    n_checks++; if (out_valid !== 4'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0000", out_valid); end
    n_checks++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
    n_checks++; if (last_grant !== 2'd0) begin n_fail++; $display("FAIL reset_last_grant: got %0d expected 0", last_grant); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_checks++; if (stall_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_stall_timeout: got %b expected 0", stall_timeout); end
    n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL reset_credit_err: got %b expected 0", credit_err); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  // Four back-to-back flits, all spines enabled: one grant per spine, 1-cycle latency
  task automatic test_back_to_back();
    logic [3:0] exp_v [6];
    exp_v = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    spine_enable = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 4);
      in_data  = 16'h0401 + 16'(i);
      step();
      n_checks++; if (out_valid !== exp_v[i]) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected %b", i, out_valid, exp_v[i]); end
      if (i >= 1 && i <= 4) begin
        n_checks++; if (out_data !== 16'h0400 + 16'(i)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, out_data, 16'h0400 + 16'(i)); end
      end
    end
    in_valid = 1'b0;
    n_checks++; if (last_grant !== 2'd3) begin n_fail++; $display("FAIL b2b_last_grant: got %0d expected 3", last_grant); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (dut.r_credit[i] !== 3'd3) begin n_fail++; $display("FAIL b2b_credit[%0d]: got %0d expected 3", i, dut.r_credit[i]); end
    end
  endtask

  // Mask 0101: grants alternate 0,2 until both spines run dry
  task automatic test_masked_rr();
    logic [3:0] exp_v [7];
    exp_v = '{4'b0000, 4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100};
    spine_enable = 4'b0101;
    for (int i = 0; i < 7; i++) begin
      in_valid = (i < 6);
      in_data  = 16'h0500 + 16'(i);
      step();
      n_checks++; if (out_valid !== exp_v[i]) begin n_fail++; $display("FAIL masked_valid[%0d]: got %b expected %b", i, out_valid, exp_v[i]); end
      if (i >= 1) begin
        n_checks++; if (out_data !== 16'h0500 + 16'(i - 1)) begin n_fail++; $display("FAIL masked_data[%0d]: got %h expected %h", i, out_data, 16'h0500 + 16'(i - 1)); end
      end
    end
    in_valid = 1'b0;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL masked_stall: got %b expected 0", stall); end
  endtask

  // Ninth flit stalls on empty credits; one return to spine 2 releases it
  task automatic test_stall_credit();
    in_valid = 1'b1; in_data = 16'h0909;
    step();
    in_valid = 1'b0;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sc_stall_set: got %b expected 1", stall); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sc_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL sc_count: got %0d expected 1", fifo_count); end
    step();
    n_checks++; if (out_valid !== 4'b0) begin n_fail++; $display("FAIL sc_no_dispatch: got %b expected 0000", out_valid); end
    credit_return = 4'b0100;
    step();
    credit_return = 4'b0000;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL sc_stall_drop: got %b expected 0", stall); end
    n_checks++; if (out_valid !== 4'b0) begin n_fail++; $display("FAIL sc_pre_dispatch: got %b expected 0000", out_valid); end
    step();
    n_checks++; if (out_valid !== 4'b0100) begin n_fail++; $display("FAIL sc_dispatch: got %b expected 0100", out_valid); end
    n_checks++; if (out_data !== 16'h0909) begin n_fail++; $display("FAIL sc_data: got %h expected 0909", out_data); end
    n_checks++; if (last_grant !== 2'd2) begin n_fail++; $display("FAIL sc_last_grant: got %0d expected 2", last_grant); end
    n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL sc_credit_err: got %b expected 0", credit_err); end
  endtask

  // Fill the FIFO with no credits, hit the stall timeout, then drain
  task automatic test_full_timeout();
    logic [3:0]  exp_v [5];
    logic [15:0] exp_d [5];
    exp_v = '{4'b0000, 4'b0001, 4'b0100, 4'b0001, 4'b0100};
    exp_d = '{16'h0000, 16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03};
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h0A00 + 16'(i);
      step();
      n_checks++; if (fifo_count !== 3'((i < 4) ? i + 1 : 4)) begin n_fail++; $display("FAIL full_count[%0d]: got %0d expected %0d", i, fifo_count, (i < 4) ? i + 1 : 4); end
      n_checks++; if (in_ready !== (i < 3)) begin n_fail++; $display("FAIL full_in_ready[%0d]: got %b expected %b", i, in_ready, (i < 3)); end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 59; i++) step();
    n_checks++; if (stall_timeout !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b expected 0", stall_timeout); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL to_stall: got %b expected 1", stall); end
    step();
    n_checks++; if (stall_timeout !== 1'b1) begin n_fail++; $display("FAIL to_set: got %b expected 1", stall_timeout); end
    credit_return = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) credit_return = 4'b0000;
      step();
      n_checks++; if (out_valid !== exp_v[i]) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b expected %b", i, out_valid, exp_v[i]); end
      if (i >= 1) begin
        n_checks++; if (out_data !== exp_d[i]) begin n_fail++; $display("FAIL drain_data[%0d]: got %h expected %h", i, out_data, exp_d[i]); end
      end
    end
    step();
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL drain_count: got %0d expected 0", fifo_count); end
    n_checks++; if (stall_timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b expected 1", stall_timeout); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL drain_stall: got %b expected 0", stall); end
    n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL drain_credit_err: got %b expected 0", credit_err); end
  endtask

  // Simultaneous dispatch+return is neutral; a return at full credit flags an error
  task automatic test_credit_edges();
    reset = 1'b1; step(); reset = 1'b0;
    n_checks++; if (stall_timeout !== 1'b0) begin n_fail++; $display("FAIL ce_timeout_cleared: got %b expected 0", stall_timeout); end
    spine_enable = 4'b0010;
    in_valid = 1'b1; in_data = 16'h0B01;
    step();
    in_valid = 1'b0;
    credit_return = 4'b0010;
    step();
    credit_return = 4'b0000;
    n_checks++; if (out_valid !== 4'b0010) begin n_fail++; $display("FAIL ce_dispatch: got %b expected 0010", out_valid); end
    n_checks++; if (dut.r_credit[1] !== 3'd4) begin n_fail++; $display("FAIL ce_credit1: got %0d expected 4", dut.r_credit[1]); end
    n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL ce_no_err: got %b expected 0", credit_err); end
    credit_return = 4'b1000;
    step();
    credit_return = 4'b0000;
    n_checks++; if (credit_err !== 1'b1) begin n_fail++; $display("FAIL ce_err: got %b expected 1", credit_err); end
    n_checks++; if (dut.r_credit[3] !== 3'd4) begin n_fail++; $display("FAIL ce_credit3: got %0d expected 4", dut.r_credit[3]); end
    step();
    n_checks++; if (credit_err !== 1'b1) begin n_fail++; $display("FAIL ce_err_sticky: got %b expected 1", credit_err); end
  endtask

  // Reset with queued flits and spent credits restores a clean state
  task automatic test_reset_mid();
    spine_enable = 4'b0100;
    in_valid = 1'b1; in_data = 16'h0C00;
    step();
    in_valid = 1'b0;
    step();
    n_checks++; if (out_valid !== 4'b0100) begin n_fail++; $display("FAIL rm_pre_grant: got %b expected 0100", out_valid); end
    spine_enable = 4'b0000;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = 16'h0C00 + 16'(i);
      step();
    end
    in_valid = 1'b0;
    n_checks++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL rm_count3: got %0d expected 3", fifo_count); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rm_stall: got %b expected 1", stall); end
    reset = 1'b1; step(); reset = 1'b0;
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rm_count0: got %0d expected 0", fifo_count); end
    n_checks++; if (out_valid !== 4'b0) begin n_fail++; $display("FAIL rm_out_valid: got %b expected 0000", out_valid); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rm_stall_clr: got %b expected 0", stall); end
    n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL rm_credit_err: got %b expected 0", credit_err); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (dut.r_credit[i] !== 3'd4) begin n_fail++; $display("FAIL rm_credit[%0d]: got %0d expected 4", i, dut.r_credit[i]); end
    end
    spine_enable = 4'b1111;
    in_valid = 1'b1; in_data = 16'h0C10;
    step();
    in_valid = 1'b0;
    step();
    n_checks++; if (out_valid !== 4'b0001) begin n_fail++; $display("FAIL rm_first_grant: got %b expected 0001", out_valid); end
    n_checks++; if (last_grant !== 2'd0) begin n_fail++; $display("FAIL rm_last_grant: got %0d expected 0", last_grant); end
    n_checks++; if (out_data !== 16'h0C10) begin n_fail++; $display("FAIL rm_data: got %h expected 0C10", out_data); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_masked_rr();
    test_stall_credit();
    test_full_timeout();
    test_credit_edges();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spine_uplink_scheduler.md
# spine_uplink_scheduler

Schedules flits from a group router's GPU-side egress onto its four spine uplinks (spine11/21/31/41). It buffers outbound flits in a small FIFO and dispatches each one to an enabled spine that holds a credit, using round-robin so load spreads evenly across the spines. It tracks per-spine credits returned by the downstream spine switches and flags stalls and credit protocol errors. It sits between the router's GPU output path and the four `spineN1_in_data`/`spineN1_in_valid` links of the spine fabric.

## Interface

Parameters:
- `DWIDTH`, 16: flit width; destination address is `flit[15:10]`, passed through unmodified.
- `CREDITS`, 4: initial and maximum credit count per spine (1–7).
- `FIFO_DEPTH`, 4: input FIFO entries (power of two).
- `STALL_TIMEOUT`, 64: consecutive STALL cycles before `stall_timeout` sets.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_data` in DWIDTH: flit from router egress.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: FIFO can accept.
- `spine_enable` in 4: config mask; bit i enables spine i (0=spine11 … 3=spine41).
- `credit_return` in 4: one pulse per cycle returns one credit to spine i.
- `out_data` out DWIDTH: dispatched flit, shared by all spines.
- `out_valid` out 4: one-hot; bit i qualifies `out_data` for spine i.
- `last_grant` out 2: index of most recently granted spine.
- `stall` out 1: head flit present, no eligible spine.
- `stall_timeout` out 1: sticky; cleared only by reset.
- `credit_err` out 1: sticky; a return arrived with the counter at `CREDITS`.
- `fifo_count` out log2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation

- Input FIFO:
  - Push when `in_valid && in_ready`.
  - `in_ready = (fifo_count != FIFO_DEPTH)`, purely from occupancy. When the FIFO is full, no push occurs even if a pop happens in the same cycle.
- Eligibility: spine i is eligible when `spine_enable[i] && credit[i] != 0`.
- Round-robin:
  - Pointer `rr_ptr` (2 bits) resets to 0.
  - Grant goes to the first eligible index scanning `rr_ptr, rr_ptr+1, …` mod 4.
  - On grant, `rr_ptr <= grant+1` (mod 4, wraps 3→0) and `last_grant <= grant`.
- Dispatch: when the FIFO is non-empty and any spine is eligible, pop the head. The same edge registers `out_data <= head` and `out_valid <= onehot(grant)`. Otherwise `out_valid <= 0` and `out_data` holds its value.
- Credits:
  - Each 3-bit counter resets to `CREDITS`.
  - Dispatch to i: −1. `credit_return[i]`: +1. Both in the same cycle: unchanged.
  - A return with the counter at `CREDITS` and no simultaneous dispatch leaves the counter unchanged and sets `credit_err`.
  - Credits are kept across `spine_enable` changes. A disabled spine still accepts returns.
- FSM (`state`):
  - IDLE: FIFO empty.
  - RUN: head present and an eligible spine exists.
  - STALL: head present and no eligible spine.
  - State is re-evaluated every cycle from next-cycle FIFO occupancy and credits.
  - `stall` is high exactly while in STALL.
  - `stall_cnt` increments in STALL and clears on leaving STALL. It saturates at `STALL_TIMEOUT`; when it reaches that value, `stall_timeout` sets.
- Disabling all spines with the FIFO non-empty leads to STALL. Flits are never dropped.

## Timing

- Reset values:
  - `out_valid=0`, `out_data=0`, `last_grant=0`, `stall=0`, `stall_timeout=0`, `credit_err=0`, `fifo_count=0`, `in_ready=1`.
  - Credits `=CREDITS`, `rr_ptr=0`, state IDLE, FIFO flushed.
- Reset mid-operation: flits queued in the FIFO and flits in flight are discarded. Credits are restored to full regardless of outstanding flits.
- Latency: a flit pushed at edge N is dispatched at edge N+1 (`out_valid` high in cycle N+1) when a spine is eligible.
- Throughput: one flit per cycle while credits last.
- `out_valid` is a single-cycle pulse per flit. There is no downstream ready; credits are the only flow control.
- A credit returned at edge N makes the spine eligible for the dispatch decision at edge N+1.

## Test plan

- Reset, then push 4 flits (`0x0401…0x0404`) with all spines enabled and credits at 4 → `out_valid` = `0001, 0010, 0100, 1000` on consecutive cycles. Each pulse comes 1 cycle after its push. Credits end at 3 each.
- `spine_enable=4'b0101`, push 6 flits, no returns → spines 0,2,0,2,0,2 granted.
- Continuing the previous case, push a 9th flit into spines 0 and 2, which now have 0 credits → `stall=1` and `in_ready` stays 1.
  - Pulse `credit_return[2]` → the flit dispatches to spine 2 the next cycle and `stall` drops.
- All credits exhausted, push flits until full with no returns → `in_ready=0` at `fifo_count=4`.
  - After 64 STALL cycles `stall_timeout=1`. It stays 1 after a later credit return drains the FIFO.
- In one cycle, dispatch to spine 1 and return a credit to spine 1 → counter unchanged.
  - With spine 3 at 4 credits, return a credit to it → `credit_err=1`, counter remains 4.
- Assert `reset` for 1 cycle while `fifo_count=3` → next cycle `fifo_count=0`, `out_valid=0`, credits 4, and the next grant goes to spine 0.
